// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned STALL_CNT_W = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_idx_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  // Scan last_idx+1 .. last_idx+NUM_REQ so the previous owner is checked last.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_idx_i) + 32'(i)) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o    = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters in bounded bursts.
// Optional stall counter output enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       fifo_full,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       busy,
  output logic                       fifo_wr_en,
`ifdef FIFO_ARB_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]     stall_cnt,
`endif
  output logic [WIDTH-1:0]           fifo_wr_data
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                owner_req;
  logic                wr;
  logic [WIDTH-1:0]    data_arr [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i      (req),
    .last_idx_i (last_idx_q),
    .winner_o   (pick_idx),
    .any_o      (pick_any)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Next-state: grant on request in IDLE; burst ends on owner drop or after MAX_BURST writes.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    burst_cnt_d = burst_cnt_q;
    owner_req   = 1'b0;
    wr          = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = BURST;
          gnt_d       = NUM_REQ'(1) << pick_idx;
          grant_idx_d = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        owner_req = req[grant_idx_q];
        wr        = owner_req & ~fifo_full;
        if (!owner_req || (wr && (burst_cnt_q == BCNT_W'(MAX_BURST - 1)))) begin
          state_d     = IDLE;
          gnt_d       = '0;
          last_idx_d  = grant_idx_q;
          burst_cnt_d = '0;
        end else if (wr) begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Reset suppresses the write so an aborted burst never emits a word.
  assign fifo_wr_en   = wr & ~rst;
  assign ack          = fifo_wr_en ? (NUM_REQ'(1) << grant_idx_q) : '0;
  assign busy         = (state_q == BURST);
  assign fifo_wr_data = busy ? data_arr[grant_idx_q] : '0;
  assign gnt          = gnt_q;
  assign grant_idx    = grant_idx_q;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles the owner was blocked by a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (owner_req && fifo_full && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned IDX_W   = 2;

  localparam bit         T2_WR   [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  localparam logic [7:0] T2_DATA [10] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                                          8'h00, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
  localparam bit         T4_WR   [9]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
  localparam bit         T4_FULL [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  localparam logic [7:0] T4_DATA [9]  = '{8'h00, 8'h50, 8'h51, 8'h00, 8'h00,
                                          8'h00, 8'h52, 8'h53, 8'h00};

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     fifo_full;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       ack;
  logic [IDX_W-1:0]         grant_idx;
  logic                     busy;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]              stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .ack          (ack),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .fifo_wr_en   (fifo_wr_en),
`ifdef FIFO_ARB_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .fifo_wr_data (fifo_wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int acks;
    int owner;
    logic [3:0] oh;

    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle
    for (int c = 0; c < 10; c++) begin
      #2;
      check("idle_gnt_busy_wr", {gnt, busy, fifo_wr_en}, 32'h0);
      if (c == 0) begin
        check("rst_grant_idx", grant_idx, 32'h0);
        check("rst_wr_data", fifo_wr_data, 32'h0);
        check("rst_ack", ack, 32'h0);
      end
      tick();
    end

    // Single requester 2, two bursts separated by one idle cycle
    k = 0;
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      req_data[2*WIDTH +: WIDTH] = 8'hA0 + 8'(k);
      #2;
      check("t2_wr_en", fifo_wr_en, 32'(T2_WR[c]));
      if (T2_WR[c]) begin
        check("t2_data", fifo_wr_data, 32'(T2_DATA[c]));
        check("t2_ack", ack, 32'h4);
      end
      if (c == 0) check("t2_gnt_c0", gnt, 32'h0);
      if (c == 1) check("t2_gnt_c1", gnt, 32'h4);
      if (c == 5) check("t2_gnt_gap", {gnt, busy}, 32'h0);
      if (ack[2]) k++;
      tick();
    end
    req = '0;
    #2;
    check("t2_after", {gnt, busy, fifo_wr_en}, 32'h0);
    tick();

    // Round-robin with all requesting: order 0,1,2,3,0 after a reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*WIDTH +: WIDTH] = 8'hC0 + 8'(i);
    req = 4'b1111;
    #2;
    check("t3_c0_gnt", gnt, 32'h0);
    tick();
    for (int g = 0; g < 5; g++) begin
      owner = g % 4;
      oh    = 4'b0001 << owner;
      acks  = 0;
      for (int c = 0; c < 4; c++) begin
        #2;
        check("t3_gnt", gnt, 32'(oh));
        check("t3_idx", grant_idx, 32'(owner));
        check("t3_data", fifo_wr_data, 32'(8'hC0 + 8'(owner)));
        if (ack == oh) acks++;
        tick();
      end
      check("t3_ack_count", acks, 32'd4);
      if (g == 4) req = '0;
      #2;
      check("t3_gap", {gnt, busy, fifo_wr_en}, 32'h0);
      tick();
    end

    // FIFO full stall on requester 1
    k = 0;
    req = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      fifo_full = T4_FULL[c];
      req_data[1*WIDTH +: WIDTH] = 8'h50 + 8'(k);
      if (c == 8) req = '0;
      #2;
      check("t4_wr_en", fifo_wr_en, 32'(T4_WR[c]));
      if (T4_WR[c]) check("t4_data", fifo_wr_data, 32'(T4_DATA[c]));
      if (T4_FULL[c]) begin
        check("t4_stall_gnt", gnt, 32'h2);
        check("t4_stall_busy", busy, 32'h1);
        check("t4_stall_ack", ack, 32'h0);
      end
      if (c == 8) begin
        check("t4_end_gnt", gnt, 32'h0);
`ifdef FIFO_ARB_STALL_CNT_EN
        check("t4_stall_cnt", stall_cnt, 32'd3);
`endif
      end
      if (ack[1]) k++;
      tick();
    end

    // Early drop by requester 3, then requester 0 wins
    req = 4'b1000;
    req_data[3*WIDTH +: WIDTH] = 8'h77;
    req_data[0*WIDTH +: WIDTH] = 8'h11;
    tick();
    #2;
    check("t5_gnt3", gnt, 32'h8);
    check("t5_data3", fifo_wr_data, 32'h77);
    check("t5_ack3", ack, 32'h8);
    tick();
    req = 4'b0001;
    #2;
    check("t5_drop_wr", fifo_wr_en, 32'h0);
    check("t5_drop_busy", busy, 32'h1);
    tick();
    #2;
    check("t5_idle", {gnt, busy}, 32'h0);
    tick();
    #2;
    check("t5_gnt0", gnt, 32'h1);
    check("t5_ack0", ack, 32'h1);
    tick();

    // Reset during requester 0's second write
    rst = 1'b1;
    #2;
    check("t6_rst_wr", fifo_wr_en, 32'h0);
    check("t6_rst_ack", ack, 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b0011;
    #2;
    check("t6_idle", {gnt, busy}, 32'h0);
    tick();
    #2;
    check("t6_regnt", gnt, 32'h1);
    check("t6_regnt_idx", grant_idx, 32'h0);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a FIFO among NUM_REQ requesters.
- Grants one requester at a time for a bounded burst.
- Drives the FIFO write enable and data, honouring fifo_full.
- Returns a per-requester write acknowledge.
- Sits between producer blocks and the FIFO write side, all in one clock domain.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width; must match the FIFO WIDTH
MAX_BURST, 4, maximum writes per grant (>=1)
IDX_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  input  1  single clock; all logic is on posedge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request; held high while data is pending
req_data  input  NUM_REQ*WIDTH  requester i's data is in slice [i*WIDTH +: WIDTH]
fifo_full  input  1  full flag from the FIFO write side
gnt  output  NUM_REQ  one-hot registered grant; all zero when idle
ack  output  NUM_REQ  one-hot; high in a cycle where the granted requester's word is written
grant_idx  output  IDX_W  index of the current owner; valid while busy=1
busy  output  1  high in BURST state
fifo_wr_en  output  1  FIFO write enable
fifo_wr_data  output  WIDTH  FIFO write data

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; gnt=0; grant_idx=0; burst_cnt=0.
  - last_idx=NUM_REQ-1, so the first arbitration favours requester 0.
  - Combinational outputs fifo_wr_en, ack and busy are 0 in IDLE; fifo_wr_data=0.
  - rst mid-burst aborts the burst with no write in that cycle.
- FSM states: IDLE, BURST.
- IDLE:
  - If |req, pick the first asserted requester scanning last_idx+1, last_idx+2, ... (mod NUM_REQ).
  - Next cycle: gnt=onehot(winner), grant_idx=winner, burst_cnt=0, state=BURST.
  - If no req, stay in IDLE.
- BURST, owner o=grant_idx:
  - write = req[o] & ~fifo_full (combinational).
  - fifo_wr_en=write; fifo_wr_data=req_data slice o; ack[o]=write.
  - On write: burst_cnt increments.
  - fifo_full=1 with req[o]=1 is a stall: hold the grant, no write, burst_cnt unchanged, no timeout.
- Burst termination (leave BURST for IDLE; at that edge last_idx=o and gnt=0):
  - req[o]=0 for a cycle → terminate with no write that cycle.
  - write with burst_cnt==MAX_BURST-1 → terminate after that write.
- Latency and throughput:
  - req in IDLE at cycle N → gnt at N+1; first write at N+1 if not full.
  - One IDLE cycle always separates bursts, so peak throughput is MAX_BURST/(MAX_BURST+1).
- Requester rules:
  - req_data must be stable while req is high.
  - A word is consumed only in a cycle with ack high.
  - Requesters other than o are ignored during BURST.
- A new req arriving during BURST does not pre-empt the owner.
- Fairness: after o's burst, o has the lowest priority; no starvation while bursts terminate.
- fifo_full is sampled combinationally; the arbiter never writes while full, so the FIFO write-error path is never exercised.

Optional Feature:
FIFO_ARB_STALL_CNT_EN
- Defined: adds output stall_cnt[15:0].
  - Increments each cycle in BURST with req[o]=1 and fifo_full=1.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE=0, BURST=1) and the STALL_CNT_W=16 constant.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last_idx.
  - Outputs: winner index, any flag.
- The FSM, burst counter and datapath mux stay in the top module.

Test Plan:
- Reset then idle: rst for 2 cycles, req=0 → gnt=0, busy=0, fifo_wr_en=0 for 10 cycles.
- Single requester burst: req[2]=1 continuously, data 0xA0..0xA7, full=0.
  - gnt=4'b0100 one cycle after req.
  - Writes 0xA0–0xA3 on consecutive cycles, then 1 idle cycle, then 0xA4–0xA7.
- Round-robin: req=4'b1111 held → grant order 0,1,2,3,0.
  - Each grant gets exactly 4 acks; 5 cycles per grant.
- Full stall: requester 1 granted, fifo_full=1 for 3 cycles after the 2nd write.
  - fifo_wr_en=0 for those 3 cycles; grant held; 2 remaining writes follow; stall_cnt=3 when the macro is defined.
- Early drop: requester 3 writes 1 word, then drops req → busy falls next edge; next grant goes to requester 0 if requested.
- Reset mid-burst: rst during the 2nd write cycle of requester 0.
  - No write that cycle; state=IDLE; next grant with req=4'b0011 goes to requester 0.
